inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
Host-side writer for the processor's 9-bit instruction memory; the producer end of the fetch path the core reads from.
- Accepts a byte stream over a valid/ready handshake and assembles 9-bit machine-code words.
- Writes each word into instruction RAM at consecutive addresses and validates the stream with an XOR checksum.
- Holds the core in reset until a load completes cleanly.

Parameters:
IW, 9, instruction address width; maximum program length is 2**IW words.
DW, 9, instruction word width; fixed by the ISA.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse that begins a (re)load.
byte_valid  input  1  byte_data holds a valid byte.
byte_data  input  8  stream byte.
byte_ready  output  1  loader accepts a byte this cycle; a transfer happens when byte_valid and byte_ready are both high.
im_wen  output  1  instruction RAM write enable, one-cycle pulse.
im_addr  output  IW  instruction RAM write address.
im_wdata  output  DW  instruction word to write.
core_reset  output  1  holds the processor in reset while high.
load_done  output  1  program loaded and checksum good.
err  output  1  load aborted (length or format or checksum error).

Behaviour:
- Reset values: byte_ready=0, im_wen=0, im_addr=0, im_wdata=0, core_reset=1, load_done=0, err=0, state=IDLE. Reset mid-load abandons the load; RAM words already written stay written.
- Stream format, little-endian:
  - CNT_LO, CNT_HI: 16-bit word count N.
  - Per word: LO byte = word[7:0]; HI byte with bit0 = word[8] and bits 7:1 required 0.
  - Trailer: CHK byte.
- Checksum: CHK must equal the XOR of every preceding byte of the load, including the count bytes. The accumulator clears on each start.
- States: IDLE, HDR_LO, HDR_HI, W_LO, W_HI, CHK, DONE, ERR.
- byte_ready is Moore: high exactly in HDR_LO, HDR_HI, W_LO, W_HI, CHK. No combinational path from byte_valid to byte_ready.
- A byte may be accepted every cycle; byte_valid low stalls the load indefinitely in the current state.
- Transitions:
  - IDLE -> HDR_LO on start.
  - HDR_LO -> HDR_HI on transfer.
  - HDR_HI on transfer:
    - N=0 -> CHK.
    - N > 2**IW -> ERR; the checksum is not read.
    - Otherwise -> W_LO with word index = 0.
  - W_LO -> W_HI on transfer; latch the low byte.
  - W_HI on transfer:
    - bits 7:1 nonzero -> ERR with no write.
    - Otherwise issue the write; go to CHK if the index equals N-1, else increment the index and go to W_LO.
  - CHK on transfer: match -> DONE, mismatch -> ERR.
- Write timing: im_wen is high for exactly one cycle, the cycle after the W_HI transfer. im_addr = word index (0 .. N-1) and im_wdata = {HI[0], LO} are valid in that cycle. Between writes im_addr and im_wdata hold their last values.
- The last write may coincide with the first cycle in CHK; that is legal.
- core_reset:
  - Goes to 1 the cycle after start is sampled.
  - Stays 1 through loading and in ERR.
  - Goes to 0 on entry to DONE, together with load_done=1.
- err=1 only in ERR. load_done=1 only in DONE.
- Both DONE and ERR are held until start or reset.
- start while in any loading state restarts at HDR_LO: clears the checksum accumulator and word index and discards the partial load. start has priority over a simultaneous byte transfer; that byte is not consumed.
- start in DONE or ERR behaves as from IDLE.
- Word index width is IW+1 so that N = 2**IW does not wrap. The N = 2**IW boundary is accepted.

Decomposition:
- Package ldr_pkg holds:
  - the state enum ldr_state_t;
  - the constant HI_RSVD_MASK = 8'hFE;
  - the localparam MAX_WORDS = 2**IW, derived via a function taking IW.
- No sub-module: the FSM, the checksum accumulator and the word counter live in one module.

Test Plan:
- Normal load: start, then bytes 02 00 23 01 C0 01 E1 -> writes (0,0x123), (1,0x1C0); DONE, load_done=1, core_reset=0, err=0.
- Bad checksum: same stream with trailer E0 -> both writes occur, then ERR, err=1, core_reset stays 1.
- Reserved bits: bytes 01 00 55 03 ... -> no im_wen, ERR immediately after the HI byte.
- Length bound:
  - count 0x0201 (513) with IW=9 -> ERR right after HDR_HI, byte_ready drops.
  - count 0x0200 accepted; last write at im_addr=0x1FF.
- Empty program: 00 00 00 -> DONE, no im_wen pulses.
- Interruptions:
  - Stall with byte_valid deasserted for 5 cycles mid-word -> state held.
  - start mid-load -> restart at HDR_LO; a following clean stream completes.
  - reset mid-load -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared types and constants for the instruction loader
package ldr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        W_LO,
        W_HI,
        CHK,
        DONE,
        ERR
    } ldr_state_t;

    // Bits 7:1 of a word's high byte are reserved and must be zero
    localparam logic [7:0] HI_RSVD_MASK = 8'hFE;

    localparam int LDR_IW = 9;

    function automatic int max_words(input int iw);
        return 1 << iw;
    endfunction

    localparam int MAX_WORDS = max_words(LDR_IW);

endpackage

// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - byte stream and instruction RAM write bus of the loader
interface inst_loader_if #(
    parameter int IW = 9,
    parameter int DW = 9
);
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          im_wen;
    logic [IW-1:0] im_addr;
    logic [DW-1:0] im_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, im_wen, im_addr, im_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, im_wen, im_addr, im_wdata
    );
endinterface

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - assembles 9-bit words from a byte stream and writes instruction RAM
module inst_loader
    import ldr_pkg::*;
#(
    parameter int IW = 9,
    parameter int DW = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    inst_loader_if.slave bus,
    output logic         core_reset,
    output logic         load_done,
    output logic         err
);

    localparam logic [15:0] MAX_N = 16'(max_words(IW));

    ldr_state_t    r_state;
    ldr_state_t    w_next;
    logic          w_ready;
    logic          w_xfer;
    logic [15:0]   w_cnt_full;
    logic          w_rsvd_bad;
    logic          w_last;

    logic [7:0]    r_chk;
    logic [15:0]   r_cnt;
    logic [IW:0]   r_idx;
    logic [7:0]    r_lo;
    logic          r_wen;
    logic [IW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    // start wins over a coincident byte, so that byte is never consumed
    assign w_xfer     = bus.byte_valid & w_ready & ~start;
    assign w_cnt_full = {bus.byte_data, r_cnt[7:0]};
    assign w_rsvd_bad = (bus.byte_data & HI_RSVD_MASK) != 8'h00;
    assign w_last     = (16'(r_idx) + 16'd1) == r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        core_reset = 1'b1;
        load_done  = 1'b0;
        err        = 1'b0;
        case (r_state)
            IDLE: ;
            HDR_LO: begin
                w_ready = 1'b1;
                if (w_xfer) w_next = HDR_HI;
            end
            HDR_HI: begin
                w_ready = 1'b1;
                if (w_xfer) begin
                    if (w_cnt_full == 16'd0)    w_next = CHK;
                    else if (w_cnt_full > MAX_N) w_next = ERR;
                    else                         w_next = W_LO;
                end
            end
            W_LO: begin
                w_ready = 1'b1;
                if (w_xfer) w_next = W_HI;
            end
            W_HI: begin
                w_ready = 1'b1;
                if (w_xfer) begin
                    if (w_rsvd_bad)  w_next = ERR;
                    else if (w_last) w_next = CHK;
                    else             w_next = W_LO;
                end
            end
            CHK: begin
                w_ready = 1'b1;
                if (w_xfer) w_next = (bus.byte_data == r_chk) ? DONE : ERR;
            end
            DONE: begin
                core_reset = 1'b0;
                load_done  = 1'b1;
            end
            ERR: err = 1'b1;
            default: w_next = IDLE;
        endcase
        if (start) w_next = HDR_LO;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_chk   <= 8'h00;
            r_cnt   <= 16'h0000;
            r_idx   <= '0;
            r_lo    <= 8'h00;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= 1'b0;
            if (start) begin
                r_chk <= 8'h00;
                r_idx <= '0;
            end else if (w_xfer) begin
                if (r_state != CHK) r_chk <= r_chk ^ bus.byte_data;
                case (r_state)
                    HDR_LO: r_cnt[7:0] <= bus.byte_data;
                    HDR_HI: begin
                        r_cnt[15:8] <= bus.byte_data;
                        r_idx       <= '0;
                    end
                    W_LO: r_lo <= bus.byte_data;
                    W_HI: begin
                        if (!w_rsvd_bad) begin
                            r_wen   <= 1'b1;
                            r_addr  <= r_idx[IW-1:0];
                            r_wdata <= {bus.byte_data[0], r_lo};
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.im_wen     = r_wen;
    assign bus.im_addr    = r_addr;
    assign bus.im_wdata   = r_wdata;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - scoreboard bench for the instruction loader
module tb_inst_loader;

    logic clk;
    logic reset;
    logic start;
    logic core_reset;
    logic load_done;
    logic err;

    int n_checks;
    int n_fail;
    logic [17:0] exp_q[$];

    inst_loader_if #(.IW(9), .DW(9)) bus();

    inst_loader #(.IW(9), .DW(9)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .core_reset (core_reset),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic [17:0] e;
        @(posedge clk);
        #1;
        if (bus.im_wen === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", bus.im_addr, bus.im_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.im_addr, bus.im_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             bus.im_addr, bus.im_wdata, e[17:9], e[8:0]);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   n;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n = 0;
        do begin
            rdy = bus.byte_ready;
            tick();
            n++;
        end while (!rdy && n < 20);
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: byte %h not accepted, required acceptance", b);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d writes missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({bus.byte_ready, bus.im_wen, bus.im_addr, bus.im_wdata, core_reset, load_done, err} !==
            {1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b wen=%b addr=%h data=%h core_reset=%b done=%b err=%b, required 0 0 000 000 1 0 0",
                     name, bus.byte_ready, bus.im_wen, bus.im_addr, bus.im_wdata, core_reset, load_done, err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset_values");
        reset = 1'b0;
        tick();
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_normal();
        pulse_start();
        check_bit("normal_ready", bus.byte_ready, 1'b1);
        exp_q.push_back({9'h000, 9'h123});
        exp_q.push_back({9'h001, 9'h1C0});
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h23); send_byte(8'h01);
        send_byte(8'hC0); send_byte(8'h01);
        send_byte(8'hE1);
        check_drained("normal_writes");
        check_bit("normal_done", load_done, 1'b1);
        check_bit("normal_core_reset", core_reset, 1'b0);
        check_bit("normal_err", err, 1'b0);
        tick();
        check_bit("done_held", load_done, 1'b1);
    endtask

    task automatic test_bad_chk();
        pulse_start();
        check_bit("restart_core_reset", core_reset, 1'b1);
        check_bit("restart_done_clear", load_done, 1'b0);
        exp_q.push_back({9'h000, 9'h123});
        exp_q.push_back({9'h001, 9'h1C0});
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h23); send_byte(8'h01);
        send_byte(8'hC0); send_byte(8'h01);
        send_byte(8'hE0);
        check_drained("badchk_writes");
        check_bit("badchk_err", err, 1'b1);
        check_bit("badchk_core_reset", core_reset, 1'b1);
        check_bit("badchk_done", load_done, 1'b0);
    endtask

    task automatic test_rsvd();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h55); send_byte(8'h03);
        check_bit("rsvd_err", err, 1'b1);
        check_bit("rsvd_ready", bus.byte_ready, 1'b0);
        tick();
        check_bit("rsvd_err_held", err, 1'b1);
    endtask

    task automatic test_len_err();
        pulse_start();
        send_byte(8'h01); send_byte(8'h02);
        check_bit("len_err", err, 1'b1);
        check_bit("len_ready", bus.byte_ready, 1'b0);
    endtask

    task automatic test_max_len();
        logic [7:0] chk;
        logic [8:0] w;
        pulse_start();
        chk = 8'h00 ^ 8'h02;
        send_byte(8'h00); send_byte(8'h02);
        check_bit("maxlen_no_err", err, 1'b0);
        for (int i = 0; i < 512; i++) begin
            w = 9'(i * 37 + 5);
            exp_q.push_back({9'(i), w});
            chk = chk ^ w[7:0] ^ {7'd0, w[8]};
            send_byte(w[7:0]);
            send_byte({7'd0, w[8]});
        end
        n_checks++;
        if (bus.im_addr !== 9'h1FF) begin
            n_fail++;
            $display("FAIL maxlen_last_addr: got %h, required 1ff", bus.im_addr);
        end
        send_byte(chk);
        check_drained("maxlen_writes");
        check_bit("maxlen_done", load_done, 1'b1);
    endtask

    task automatic test_empty();
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check_bit("empty_done", load_done, 1'b1);
        check_bit("empty_core_reset", core_reset, 1'b0);
    endtask

    task automatic test_stall();
        pulse_start();
        exp_q.push_back({9'h000, 9'h134});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h34);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_bit("stall_ready", bus.byte_ready, 1'b1);
        end
        check_bit("stall_not_done", load_done, 1'b0);
        send_byte(8'h01);
        send_byte(8'h34);
        check_drained("stall_writes");
        check_bit("stall_done", load_done, 1'b1);
    endtask

    task automatic test_restart();
        pulse_start();
        exp_q.push_back({9'h000, 9'h011});
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h00);
        check_drained("restart_partial");
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        pulse_start();
        bus.byte_valid = 1'b0;
        exp_q.push_back({9'h000, 9'h1FF});
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hFF); send_byte(8'h01);
        send_byte(8'hFF);
        check_drained("restart_writes");
        check_bit("restart_done", load_done, 1'b1);
        check_bit("restart_err", err, 1'b0);
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h23);
        reset = 1'b1;
        tick();
        check_reset_outputs("reset_mid");
        reset = 1'b0;
        tick();
        exp_q.push_back({9'h000, 9'h123});
        exp_q.push_back({9'h001, 9'h1C0});
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h23); send_byte(8'h01);
        send_byte(8'hC0); send_byte(8'h01);
        send_byte(8'hE1);
        check_drained("after_reset_writes");
        check_bit("after_reset_done", load_done, 1'b1);
    endtask

    initial begin
        clk            = 1'b0;
        reset          = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        n_checks       = 0;
        n_fail         = 0;
        test_reset();
        test_normal();
        test_bad_chk();
        test_rsvd();
        test_len_err();
        test_max_len();
        test_empty();
        test_stall();
        test_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
